// File: rtl/restoring_divider_8x4.sv
// restoring_divider_8x4
// Sequential unsigned divider: 8-bit dividend / 4-bit divisor. Each clock
// performs one restoring iteration. The result appears 8 edges after the
// accept edge, or 1 edge after it when the divisor is zero.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid / in_ready    operand handshake (in_ready high only in IDLE)
//   dividend, divisor      operands, sampled on the accept edge
//   out_valid / out_ready  result handshake (out_valid high only in DONE)
//   quotient, remainder    registered result
//   div_by_zero            registered flag: last result had divisor == 0
module restoring_divider_8x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [4:0] pr_q, pr_d;
  logic [7:0] dvd_q, dvd_d;     // dividend shift register, MSB consumed first
  logic [3:0] dvs_q, dvs_d;
  logic [7:0] wq_q, wq_d;       // working quotient
  logic [7:0] quotient_q, quotient_d;
  logic [3:0] remainder_q, remainder_d;
  logic       dbz_q, dbz_d;

  logic [4:0] t;
  logic [4:0] pr_next;
  logic       qbit;

  // One restoring step on the current work registers.
  always_comb begin
    t = {pr_q[3:0], dvd_q[7]};
    if (t >= {1'b0, dvs_q}) begin
      pr_next = t - {1'b0, dvs_q};
      qbit    = 1'b1;
    end else begin
      pr_next = t;
      qbit    = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pr_d        = pr_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    wq_d        = wq_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d = dividend;
          dvs_d = divisor;
          cnt_d = '0;
          pr_d  = '0;
          wq_d  = '0;
          if (divisor == 4'd0) begin
            quotient_d  = 8'hFF;
            remainder_d = dividend[3:0];
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        pr_d  = pr_next;
        dvd_d = {dvd_q[6:0], 1'b0};
        wq_d  = {wq_q[6:0], qbit};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          quotient_d  = {wq_q[6:0], qbit};
          remainder_d = pr_next[3:0];
          dbz_d       = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pr_q        <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      wq_q        <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pr_q        <= pr_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      wq_q        <= wq_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_8x4.sv
// Bench for restoring_divider_8x4: directed vectors with literal expectations,
// an arithmetic reference model, and a per-cycle result compare process.
module tb_restoring_divider_8x4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;

  // Expected result of the operation currently in flight.
  logic [7:0] exp_q;
  logic [3:0] exp_r;
  logic       exp_z;

  restoring_divider_8x4 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_q(input logic [7:0] a, input logic [3:0] b);
    if (b == 4'd0) return 8'hFF;
    return 8'(int'(a) / int'(b));
  endfunction

  function automatic logic [3:0] model_r(input logic [7:0] a, input logic [3:0] b);
    if (b == 4'd0) return a[3:0];
    return 4'(int'(a) % int'(b));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Whenever a result is presented it must match the model for the accepted operands.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      check("cmp_quotient", int'(quotient), int'(exp_q));
      check("cmp_remainder", int'(remainder), int'(exp_r));
      check("cmp_dbz", int'(div_by_zero), int'(exp_z));
      check("cmp_ready_low_in_done", int'(in_ready), 0);
    end
  end

  // Issue one operation, wait for the result, stall, then hand it off.
  // pulse: drive junk operands with in_valid high while the block is busy,
  // including on the output handshake edge.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                       input logic [7:0] lq, input logic [3:0] lr,
                       input int stall, input int lat, input bit pulse);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", int'(in_ready), 1);
    exp_q     = model_q(a, b);
    exp_r     = model_r(a, b);
    exp_z     = (b == 4'd0);
    out_ready = 1'b0;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = pulse;
    dividend = 8'h55;
    divisor  = 4'h2;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 30);
    check("latency", n, lat);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("held_valid", int'(out_valid), 1);
      check("busy_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("valid_drop", int'(out_valid), 0);
    check("ready_back", int'(in_ready), 1);
    check("lit_quotient", int'(quotient), int'(lq));
    check("lit_remainder", int'(remainder), int'(lr));
    check("lit_dbz", int'(div_by_zero), int'(b == 4'd0));
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    exp_q     = '0;
    exp_r     = '0;
    exp_z     = 1'b0;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);

    // Pin the reference model with hand-computed values.
    check("model_200_7_q", int'(model_q(8'd200, 4'd7)), 28);
    check("model_200_7_r", int'(model_r(8'd200, 4'd7)), 4);
    check("model_a7_0_q", int'(model_q(8'hA7, 4'd0)), 255);
    check("model_a7_0_r", int'(model_r(8'hA7, 4'd0)), 7);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_op(8'd200, 4'd7,  8'd28,  4'd4, 0, 8, 1'b0);
    do_op(8'd255, 4'd1,  8'd255, 4'd0, 0, 8, 1'b0);
    do_op(8'd5,   4'd9,  8'd0,   4'd5, 1, 8, 1'b0);
    do_op(8'd255, 4'd15, 8'd17,  4'd0, 0, 8, 1'b0);
    do_op(8'hA7,  4'd0,  8'hFF,  4'h7, 0, 1, 1'b0);
    do_op(8'd100, 4'd3,  8'd33,  4'd1, 5, 8, 1'b1);

    // Reset four edges into a 200/7 run.
    @(negedge clk);
    exp_q    = model_q(8'd200, 4'd7);
    exp_r    = model_r(8'd200, 4'd7);
    exp_z    = 1'b0;
    dividend = 8'd200;
    divisor  = 4'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_quotient", int'(quotient), 0);
    check("midrst_remainder", int'(remainder), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    n = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    check("midrst_no_result", n, 0);
    out_ready = 1'b0;
    do_op(8'd9, 4'd2, 8'd4, 4'd1, 0, 8, 1'b0);

    // Multiplier inverse: (a*b)/b must give a with no remainder.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_op(8'(a * b), 4'(b), 8'(a), 4'd0, int'($urandom_range(0, 2)), 8, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
